// File: rtl/noc_pkg.sv
// Shared definitions for the buffered torus switch: flit field offsets,
// routing modes, port indices, route computation and round-robin helpers.
package noc_pkg;

  // Routing modes
  localparam int unsigned ROUTE_XY = 0;
  localparam int unsigned ROUTE_YX = 1;

  localparam int NUM_PORTS = 3;

  // Ingress port indices; also the round-robin order
  localparam logic [1:0] PORT_L  = 2'd0;
  localparam logic [1:0] PORT_B  = 2'd1;
  localparam logic [1:0] PORT_PE = 2'd2;

  // Egress port indices
  localparam logic [1:0] OUT_R  = 2'd0;
  localparam logic [1:0] OUT_T  = 2'd1;
  localparam logic [1:0] OUT_PE = 2'd2;

  // Bit offset of the destination-x field inside a flit
  function automatic int unsigned dest_x_lsb(int unsigned data_width);
    return data_width;
  endfunction

  // Bit offset of the destination-y field inside a flit
  function automatic int unsigned dest_y_lsb(int unsigned data_width, int unsigned x_size);
    return data_width + x_size;
  endfunction

  // Egress port for a flit at node (here_x, here_y)
  function automatic logic [1:0] route_compute(int unsigned dest_x, int unsigned dest_y,
                                               int unsigned here_x, int unsigned here_y,
                                               int unsigned route_mode);
    logic x_hit;
    logic y_hit;
    logic [1:0] port;
    x_hit = (dest_x == here_x);
    y_hit = (dest_y == here_y);
    if (route_mode == ROUTE_YX) begin
      if (!y_hit) begin
        port = OUT_T;
      end else if (!x_hit) begin
        port = OUT_R;
      end else begin
        port = OUT_PE;
      end
    end else begin
      if (!x_hit) begin
        port = OUT_R;
      end else if (!y_hit) begin
        port = OUT_T;
      end else begin
        port = OUT_PE;
      end
    end
    return port;
  endfunction

  // Next ingress in round-robin order L -> B -> PE -> L
  function automatic logic [1:0] port_next(logic [1:0] p);
    return (p == PORT_PE) ? PORT_L : p + 2'd1;
  endfunction

  // One-hot grant: first requester at or after ptr in round-robin order
  function automatic logic [NUM_PORTS-1:0] rr_grant(logic [NUM_PORTS-1:0] req, logic [1:0] ptr);
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [NUM_PORTS-1:0] gnt;
    p0  = ptr;
    p1  = port_next(p0);
    p2  = port_next(p1);
    gnt = '0;
    if (req[p0]) begin
      gnt[p0] = 1'b1;
    end else if (req[p1]) begin
      gnt[p1] = 1'b1;
    end else if (req[p2]) begin
      gnt[p2] = 1'b1;
    end
    return gnt;
  endfunction

  // Index of the set bit of a one-hot grant (L when empty)
  function automatic logic [1:0] grant_index(logic [NUM_PORTS-1:0] gnt);
    logic [1:0] idx;
    if (gnt[PORT_B]) begin
      idx = PORT_B;
    end else if (gnt[PORT_PE]) begin
      idx = PORT_PE;
    end else begin
      idx = PORT_L;
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with registered count; full/empty derive from the count so
// the ingress ready never depends combinationally on egress activity.
module noc_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [width-1:0]             din,
  input  logic                         pop,
  output logic [width-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth):0]       count
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [width-1:0] mem [depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CntW'(depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  // A push while full is dropped; ready is low then, so no handshake occurs
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy state; pointers wrap naturally (depth is a power of two)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/torus_buffered_switch.sv
// Buffered 3x3 torus switch node: input FIFOs on L/B/PE, per-egress round-robin
// arbitration and an output register on R/T/PE, valid/ready on every port.
module torus_buffered_switch
  import noc_pkg::*;
#(
  parameter int unsigned X           = 4,
  parameter int unsigned Y           = 4,
  parameter int unsigned x_coord     = 0,
  parameter int unsigned y_coord     = 0,
  parameter int unsigned data_width  = 256,
  parameter int unsigned x_size      = 2,
  parameter int unsigned y_size      = 2,
  parameter int unsigned total_width = x_size + y_size + data_width,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ROUTE_MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid_l,
  input  logic [total_width-1:0] i_data_l,
  output logic                   o_ready_l,
  input  logic                   i_valid_b,
  input  logic [total_width-1:0] i_data_b,
  output logic                   o_ready_b,
  input  logic                   i_valid_pe,
  input  logic [total_width-1:0] i_data_pe,
  output logic                   o_ready_pe,
  output logic                   o_valid_r,
  output logic [total_width-1:0] o_data_r,
  input  logic                   i_ready_r,
  output logic                   o_valid_t,
  output logic [total_width-1:0] o_data_t,
  input  logic                   i_ready_t,
  output logic                   o_valid_pe,
  output logic [total_width-1:0] o_data_pe,
  input  logic                   i_ready_pe
);

  localparam int unsigned XLsb  = dest_x_lsb(data_width);
  localparam int unsigned YLsb  = dest_y_lsb(data_width, x_size);
  localparam int unsigned HereX = x_coord % X;
  localparam int unsigned HereY = y_coord % Y;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  // Ingress side, indexed by PORT_*
  logic [NUM_PORTS-1:0]   in_valid;
  logic [NUM_PORTS-1:0]   in_ready;
  logic [NUM_PORTS-1:0]   push;
  logic [NUM_PORTS-1:0]   pop;
  logic [NUM_PORTS-1:0]   head_valid;
  logic [NUM_PORTS-1:0]   fifo_full;
  logic [NUM_PORTS-1:0]   fifo_empty;
  logic [total_width-1:0] in_data    [NUM_PORTS];
  logic [total_width-1:0] head_data  [NUM_PORTS];
  logic [CntW-1:0]        fifo_count [NUM_PORTS];
  logic [1:0]             route      [NUM_PORTS];

  // Egress side, indexed by OUT_*
  logic [NUM_PORTS-1:0]   out_ready;
  logic [NUM_PORTS-1:0]   out_valid;
  logic [total_width-1:0] out_data [NUM_PORTS];
  // Per egress: one-hot of the ingress FIFO it pops this cycle
  logic [NUM_PORTS-1:0]   take     [NUM_PORTS];

  assign in_valid         = {i_valid_pe, i_valid_b, i_valid_l};
  assign in_data[PORT_L]  = i_data_l;
  assign in_data[PORT_B]  = i_data_b;
  assign in_data[PORT_PE] = i_data_pe;
  assign o_ready_l        = in_ready[PORT_L];
  assign o_ready_b        = in_ready[PORT_B];
  assign o_ready_pe       = in_ready[PORT_PE];

  assign out_ready        = {i_ready_pe, i_ready_t, i_ready_r};
  assign o_valid_r        = out_valid[OUT_R];
  assign o_data_r         = out_data[OUT_R];
  assign o_valid_t        = out_valid[OUT_T];
  assign o_data_t         = out_data[OUT_T];
  assign o_valid_pe       = out_valid[OUT_PE];
  assign o_data_pe        = out_data[OUT_PE];

  // Occupancy is only observed through full/empty
  logic unused_count;
  assign unused_count = ^{fifo_count[PORT_L], fifo_count[PORT_B], fifo_count[PORT_PE]};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    noc_fifo #(
      .width (total_width),
      .depth (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (in_data[i]),
      .pop   (pop[i]),
      .dout  (head_data[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .count (fifo_count[i])
    );

    assign in_ready[i]   = !fifo_full[i];
    assign push[i]       = in_valid[i] && in_ready[i];
    assign head_valid[i] = !fifo_empty[i];
    assign route[i]      = route_compute(32'(head_data[i][XLsb +: x_size]),
                                         32'(head_data[i][YLsb +: y_size]),
                                         HereX, HereY, ROUTE_MODE);
  end

  // Each head requests exactly one egress, so at most one egress pops it
  assign pop = take[OUT_R] | take[OUT_T] | take[OUT_PE];

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0]   req;
    logic [NUM_PORTS-1:0]   gnt;
    logic                   load;
    logic                   valid_q;
    logic [total_width-1:0] data_q;
    logic [total_width-1:0] win_data;
    logic [1:0]             ptr_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
      assign req[i] = head_valid[i] && (route[i] == 2'(o));
    end

    assign gnt      = rr_grant(req, ptr_q);
    // Load into an empty register, or replace a flit leaving this cycle
    assign load     = (|req) && (!valid_q || out_ready[o]);
    assign win_data = ({total_width{gnt[PORT_L]}}  & head_data[PORT_L])
                    | ({total_width{gnt[PORT_B]}}  & head_data[PORT_B])
                    | ({total_width{gnt[PORT_PE]}} & head_data[PORT_PE]);
    assign take[o]  = load ? gnt : '0;

    // Output register and arbiter pointer; data only changes on load so it
    // stays stable while the downstream stalls
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        ptr_q   <= PORT_L;
      end else if (load) begin
        valid_q <= 1'b1;
        data_q  <= win_data;
        ptr_q   <= port_next(grant_index(gnt));
      end else if (out_ready[o]) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid[o] = valid_q;
    assign out_data[o]  = data_q;
  end

endmodule

// File: tb/tb_torus_buffered_switch.sv
// Self-checking bench: directed scenarios plus random traffic, scored against
// a per-(source, egress) ordered queue model derived from the routing rules.
module tb_torus_buffered_switch;

  localparam int DW = 16;
  localparam int XS = 2;
  localparam int YS = 2;
  localparam int TW = DW + XS + YS;
  localparam int NX = 1;
  localparam int NY = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic vl = 0, vb = 0, vp = 0;
  logic [TW-1:0] dl = '0, db = '0, dp = '0;
  logic rl, rb, rp;
  logic ovr, ovt, ovp;
  logic [TW-1:0] odr, odt, odp;
  logic irr = 1, irt = 1, irp = 1;

  // Second node (0,0) in YX mode, only its PE ingress is driven
  logic y_vp = 0;
  logic [TW-1:0] y_dp = '0;
  logic y_rl, y_rb, y_rp, y_ovr, y_ovt, y_ovp;
  logic [TW-1:0] y_odr, y_odt, y_odp;

  torus_buffered_switch #(
    .X(4), .Y(4), .x_coord(NX), .y_coord(NY), .data_width(DW), .x_size(XS), .y_size(YS),
    .FIFO_DEPTH(4), .ROUTE_MODE(0)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid_l(vl), .i_data_l(dl), .o_ready_l(rl),
    .i_valid_b(vb), .i_data_b(db), .o_ready_b(rb),
    .i_valid_pe(vp), .i_data_pe(dp), .o_ready_pe(rp),
    .o_valid_r(ovr), .o_data_r(odr), .i_ready_r(irr),
    .o_valid_t(ovt), .o_data_t(odt), .i_ready_t(irt),
    .o_valid_pe(ovp), .o_data_pe(odp), .i_ready_pe(irp)
  );

  torus_buffered_switch #(
    .X(4), .Y(4), .x_coord(0), .y_coord(0), .data_width(DW), .x_size(XS), .y_size(YS),
    .FIFO_DEPTH(4), .ROUTE_MODE(1)
  ) dut_yx (
    .clk(clk), .rst(rst),
    .i_valid_l(1'b0), .i_data_l('0), .o_ready_l(y_rl),
    .i_valid_b(1'b0), .i_data_b('0), .o_ready_b(y_rb),
    .i_valid_pe(y_vp), .i_data_pe(y_dp), .o_ready_pe(y_rp),
    .o_valid_r(y_ovr), .o_data_r(y_odr), .i_ready_r(1'b1),
    .o_valid_t(y_ovt), .o_data_t(y_odt), .i_ready_t(1'b1),
    .o_valid_pe(y_ovp), .o_data_pe(y_odp), .i_ready_pe(1'b1)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Expected flits per (source, egress), index src*3+out; order must be kept
  logic [TW-1:0] mq [9][$];
  int egress_cnt [3];
  logic stall_q [3];
  logic [TW-1:0] stall_d [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = right, 1 = top, 2 = PE
  function automatic int ref_route(int dx, int dy, int hx, int hy, int mode);
    if (mode == 0) begin
      if (dx != hx) return 0;
      if (dy != hy) return 1;
      return 2;
    end
    if (dy != hy) return 1;
    if (dx != hx) return 0;
    return 2;
  endfunction

  // Payload carries source in the top two bits and a sequence number below
  function automatic logic [TW-1:0] make_flit(int src, int seq, int dx, int dy);
    logic [TW-1:0] f;
    f = '0;
    f[DW-1 -: 2]   = src[1:0];
    f[DW-3:0]      = seq[DW-3:0];
    f[DW +: XS]    = dx[XS-1:0];
    f[DW+XS +: YS] = dy[YS-1:0];
    return f;
  endfunction

  function automatic int src_of(logic [TW-1:0] f);
    return int'(f[DW-1 -: 2]);
  endfunction

  function automatic int queued();
    int s = 0;
    for (int k = 0; k < 9; k++) s += mq[k].size();
    return s;
  endfunction

  task automatic model_push(input int src, input logic [TW-1:0] f);
    int o;
    o = ref_route(int'(f[DW +: XS]), int'(f[DW+XS +: YS]), NX, NY, 0);
    mq[src*3+o].push_back(f);
  endtask

  task automatic check_egress(input int o, input logic v, input logic r, input logic [TW-1:0] d);
    int src;
    logic [TW-1:0] e;
    if (stall_q[o]) begin
      check("hold_valid", v, 1);
      check("hold_data", d, stall_d[o]);
    end
    stall_q[o] = v && !r;
    stall_d[o] = d;
    if (v && r) begin
      egress_cnt[o]++;
      src = src_of(d);
      if (src > 2) begin
        check("egress_src_tag", src, 0);
      end else begin
        check("egress_pending", mq[src*3+o].size() != 0, 1);
        if (mq[src*3+o].size() != 0) begin
          e = mq[src*3+o].pop_front();
          check("egress_data", d, e);
        end
      end
    end
  endtask

  // Record handshakes visible now, then advance one clock to the next falling edge
  task automatic tick();
    if (!rst) begin
      if (vl && rl) model_push(0, dl);
      if (vb && rb) model_push(1, db);
      if (vp && rp) model_push(2, dp);
      check_egress(0, ovr, irr, odr);
      check_egress(1, ovt, irt, odt);
      check_egress(2, ovp, irp, odp);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 9; k++) mq[k].delete();
    for (int o = 0; o < 3; o++) stall_q[o] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    vl = 0; vb = 0; vp = 0; y_vp = 0;
    rst = 1;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_valid", {ovp, ovt, ovr}, 0);
    check("rst_ready", {rp, rb, rl}, 3'b111);
    rst = 0;
    clear_model();
  endtask

  task automatic drain(input string tag);
    irr = 1; irt = 1; irp = 1;
    vl = 0; vb = 0; vp = 0;
    for (int c = 0; c < 200; c++) begin
      if (queued() == 0 && !ovr && !ovt && !ovp) break;
      tick();
    end
    check(tag, queued(), 0);
  endtask

  task automatic pe_latency(input string tag, input int dx, input int dy, input int exp_out);
    check({tag, "_ready"}, rp, 1);
    dp = make_flit(2, dx * 4 + dy, dx, dy);
    vp = 1;
    tick();
    vp = 0;
    check({tag, "_early"}, {ovp, ovt, ovr}, 0);
    tick();
    check({tag, "_valid"}, {ovp, ovt, ovr}, 3'b001 << exp_out);
    tick();
    check({tag, "_once"}, {ovp, ovt, ovr}, 0);
  endtask

  initial begin
    int seq [3];
    int k, acc, t_start, r_start;
    logic first_seen, hl, hb, hp;

    for (int o = 0; o < 3; o++) begin
      egress_cnt[o] = 0;
      stall_q[o] = 0;
      stall_d[o] = '0;
    end
    @(negedge clk);

    // Reset and idle
    do_reset(2);
    check("rst_data", {odr, odt, odp}, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_valid", {ovp, ovt, ovr}, 0);
    end

    // Latency and routing from PE at node (1,1), XY
    pe_latency("lat_r", 3, 1, 0);
    pe_latency("lat_t", 1, 2, 1);
    pe_latency("lat_pe", 1, 1, 2);

    // Same flit (2,3): R here in XY, T at node (0,0) in YX
    y_dp = make_flit(2, 99, 2, 3);
    y_vp = 1;
    dp = make_flit(2, 99, 2, 3);
    vp = 1;
    tick();
    vp = 0; y_vp = 0;
    tick();
    check("xy_exit_r", {ovp, ovt, ovr}, 3'b001);
    check("yx_exit_t", {y_ovp, y_ovt, y_ovr}, 3'b010);
    check("yx_data", y_odt, make_flit(2, 99, 2, 3));
    tick();

    // Three sources streaming to PE egress
    do_reset(1);
    seq = '{0, 0, 0};
    first_seen = 0;
    k = 0;
    for (int c = 0; c < 60 && k < 12; c++) begin
      dl = make_flit(0, seq[0], NX, NY);
      db = make_flit(1, seq[1], NX, NY);
      dp = make_flit(2, seq[2], NX, NY);
      vl = 1; vb = 1; vp = 1;
      if (first_seen) begin
        check("stream_valid", ovp, 1);
        check("stream_order", ovp ? src_of(odp) : 3, k % 3);
        k++;
      end else if (ovp) begin
        first_seen = 1;
        check("stream_order", src_of(odp), 0);
        k = 1;
      end
      hl = vl && rl; hb = vb && rb; hp = vp && rp;
      tick();
      if (hl) seq[0]++;
      if (hb) seq[1]++;
      if (hp) seq[2]++;
    end
    check("stream_count", k, 12);
    drain("stream_drain");

    // R blocked: L fills up while B->T keeps flowing
    do_reset(1);
    irr = 0;
    acc = 0;
    seq[1] = 0;
    t_start = egress_cnt[1];
    for (int c = 0; c < 12; c++) begin
      vl = (acc < 6);
      dl = make_flit(0, acc, 2, 1);
      vb = 1;
      db = make_flit(1, seq[1], 1, 2);
      hl = vl && rl; hb = vb && rb;
      tick();
      if (hl) acc++;
      if (hb) seq[1]++;
    end
    check("bp_accepts", acc, 5);
    check("bp_ready_low", rl, 0);
    check("bp_t_flowing", (egress_cnt[1] - t_start) >= 8, 1);
    r_start = egress_cnt[0];
    drain("bp_drain");
    check("bp_r_drained", egress_cnt[0] - r_start, 5);

    // Reset with three flits buffered flushes them
    irr = 0;
    for (int c = 0; c < 3; c++) begin
      dl = make_flit(0, 200 + c, 3, 1);
      vl = 1;
      tick();
    end
    vl = 0;
    tick();
    check("flush_pre_valid", ovr, 1);
    do_reset(1);
    irr = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("flush_no_leak", {ovp, ovt, ovr}, 0);
    end

    // Random traffic with random backpressure
    seq = '{0, 0, 0};
    for (int c = 0; c < 400; c++) begin
      if (!vl && $urandom_range(0, 1) == 1) begin
        vl = 1;
        dl = make_flit(0, seq[0]++, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if (!vb && $urandom_range(0, 1) == 1) begin
        vb = 1;
        db = make_flit(1, seq[1]++, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if (!vp && $urandom_range(0, 1) == 1) begin
        vp = 1;
        dp = make_flit(2, seq[2]++, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      irr = ($urandom_range(0, 3) != 0);
      irt = ($urandom_range(0, 3) != 0);
      irp = ($urandom_range(0, 3) != 0);
      hl = vl && rl; hb = vb && rb; hp = vp && rp;
      tick();
      if (hl) vl = 0;
      if (hb) vb = 0;
      if (hp) vp = 0;
    end
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
